// File: rtl/proximity_pkg.sv
// Shared types and elaboration-time helpers for the proximity detector.
package proximity_pkg;

  typedef enum logic [1:0] {
    ST_FAR       = 2'd0,
    ST_NEAR_PEND = 2'd1,
    ST_NEAR      = 2'd2,
    ST_FAR_PEND  = 2'd3
  } prox_state_e;

  function automatic int sum_width(input int dist_w, input int avg_log2);
    return dist_w + avg_log2;
  endfunction

  function automatic longint timeout_cycles(input longint clk_hz, input longint timeout_ms);
    return (clk_hz / 64'd1000) * timeout_ms;
  endfunction

  function automatic bit params_ok(input int near_cm, input int far_cm, input int hold);
    return (far_cm > near_cm) && (hold >= 1);
  endfunction

endpackage

// File: rtl/proximity_detector_moving_avg.sv
// Power-of-two moving average over accepted distance samples, with flush.
module moving_avg
  import proximity_pkg::*;
#(
  parameter int DIST_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DIST_W-1:0] sample_i,
  input  logic              flush_i,
  output logic [DIST_W-1:0] avg_o,
  output logic              avg_valid_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = sum_width(DIST_W, AVG_LOG2);
  localparam logic [AVG_LOG2:0]   FULL    = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0]   FILL_1  = (AVG_LOG2 + 1)'(1);
  localparam logic [AVG_LOG2-1:0] PTR_ONE = AVG_LOG2'(1);

  logic [DIST_W-1:0]   buf_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DIST_W-1:0]   oldest_s;
  logic [DIST_W-1:0]   avg_q;
  logic                avg_valid_q;

  // Next running sum and fill level; the slot being overwritten counts only once the ring is full.
  always_comb begin
    sum_d  = sum_q;
    fill_d = fill_q;
    if (fill_q == FULL) begin
      oldest_s = buf_q[wr_ptr_q];
    end else begin
      oldest_s = '0;
    end
    if (push_i) begin
      sum_d  = sum_q + SUM_W'(sample_i) - SUM_W'(oldest_s);
      fill_d = (fill_q == FULL) ? fill_q : fill_q + FILL_1;
    end else if (flush_i) begin
      sum_d  = '0;
      fill_d = '0;
    end else begin
      sum_d  = sum_q;
      fill_d = fill_q;
    end
  end

  // Ring buffer, sum, fill and registered average outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      fill_q <= fill_d;
      if (push_i) begin
        buf_q[wr_ptr_q] <= sample_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
        avg_q           <= sum_d[SUM_W-1:AVG_LOG2];
        avg_valid_q     <= (fill_d == FULL);
      end else if (flush_i) begin
        wr_ptr_q    <= '0;
        avg_q       <= '0;
        avg_valid_q <= 1'b0;
      end else begin
        avg_valid_q <= 1'b0;
      end
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/proximity_detector.sv
// Debounced proximity flag from ultrasonic distance samples, with hysteresis
// and a sensor-silence fault that flushes the averager.
module proximity_detector
  import proximity_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int DIST_W     = 16,
  parameter int AVG_LOG2   = 2,
  parameter int MAX_CM     = 400,
  parameter int NEAR_CM    = 10,
  parameter int FAR_CM     = 15,
  parameter int HOLD       = 3,
  parameter int TIMEOUT_MS = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DIST_W-1:0] sample_cm,
  output logic [DIST_W-1:0] avg_cm,
  output logic              avg_valid,
  output logic              near,
  output logic              near_rise,
  output logic              near_fall,
  output logic              sensor_fault
);

  if (!params_ok(NEAR_CM, FAR_CM, HOLD)) begin : g_param_check
    $error("proximity_detector: FAR_CM must exceed NEAR_CM and HOLD must be at least 1");
  end

  localparam int TO_LIMIT = int'(timeout_cycles(longint'(CLK_HZ), longint'(TIMEOUT_MS)));
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_LIMIT);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD);

  logic              accept_s;
  logic              timeout_hit_s;
  logic [TO_W-1:0]   to_q, to_d;
  logic              fault_q, fault_d;
  logic [DIST_W-1:0] avg_cm_s;
  logic              avg_valid_s;
  logic              near_cand_s, far_cand_s;
  prox_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              near_q, near_d;
  logic              rise_q, fall_q;

  assign accept_s = sample_valid && (sample_cm >= DIST_W'(1)) && (sample_cm <= DIST_W'(MAX_CM));

  moving_avg #(
    .DIST_W  (DIST_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk        (clk),
    .reset      (reset),
    .push_i     (accept_s),
    .sample_i   (sample_cm),
    .flush_i    (timeout_hit_s),
    .avg_o      (avg_cm_s),
    .avg_valid_o(avg_valid_s)
  );

  // Silence timer: an accepted sample always wins over the limit; the counter parks at the limit.
  always_comb begin
    timeout_hit_s = 1'b0;
    to_d          = to_q;
    fault_d       = fault_q;
    if (accept_s) begin
      to_d    = '0;
      fault_d = 1'b0;
    end else if (to_q == TO_LAST) begin
      to_d          = TO_MAX;
      fault_d       = 1'b1;
      timeout_hit_s = 1'b1;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + TO_ONE;
    end else begin
      to_d = to_q;
    end
  end

  assign near_cand_s = (avg_cm_s <= DIST_W'(NEAR_CM));
  assign far_cand_s  = (avg_cm_s >= DIST_W'(FAR_CM));

  // Hysteresis FSM, stepped only by fresh averages and forced to FAR on timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (timeout_hit_s) begin
      state_d = ST_FAR;
      cnt_d   = '0;
    end else if (avg_valid_s) begin
      case (state_q)
        ST_FAR: begin
          if (near_cand_s) begin
            state_d = (HOLD == 1) ? ST_NEAR : ST_NEAR_PEND;
            cnt_d   = (HOLD == 1) ? '0 : CNT_ONE;
          end else begin
            state_d = ST_FAR;
            cnt_d   = '0;
          end
        end
        ST_NEAR_PEND: begin
          if (!near_cand_s) begin
            state_d = ST_FAR;
            cnt_d   = '0;
          end else if ((cnt_q + CNT_ONE) == CNT_HOLD) begin
            state_d = ST_NEAR;
            cnt_d   = '0;
          end else begin
            state_d = ST_NEAR_PEND;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_NEAR: begin
          if (far_cand_s) begin
            state_d = (HOLD == 1) ? ST_FAR : ST_FAR_PEND;
            cnt_d   = (HOLD == 1) ? '0 : CNT_ONE;
          end else begin
            state_d = ST_NEAR;
            cnt_d   = '0;
          end
        end
        ST_FAR_PEND: begin
          if (!far_cand_s) begin
            state_d = ST_NEAR;
            cnt_d   = '0;
          end else if ((cnt_q + CNT_ONE) == CNT_HOLD) begin
            state_d = ST_FAR;
            cnt_d   = '0;
          end else begin
            state_d = ST_FAR_PEND;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_FAR;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
    near_d = (state_d == ST_NEAR) || (state_d == ST_FAR_PEND);
  end

  // State, timer and flag registers; edge pulses are registered alongside near.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FAR;
      cnt_q   <= '0;
      to_q    <= '0;
      fault_q <= 1'b0;
      near_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      fault_q <= fault_d;
      near_q  <= near_d;
      rise_q  <= near_d & ~near_q;
      fall_q  <= ~near_d & near_q;
    end
  end

  assign avg_cm       = avg_cm_s;
  assign avg_valid    = avg_valid_s;
  assign near         = near_q;
  assign near_rise    = rise_q;
  assign near_fall    = fall_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_proximity_detector.sv
// Scoreboard bench for proximity_detector: directed samples with hand-computed averages.
module tb_proximity_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_cm;
  logic [15:0] avg_cm;
  logic        avg_valid;
  logic        near;
  logic        near_rise;
  logic        near_fall;
  logic        sensor_fault;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] avg;
    logic        nr;
    logic        rise;
    logic        fall;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pend   = 1'b0;
  bit   strict = 1'b1;

  proximity_detector #(
    .CLK_HZ    (1000),
    .DIST_W    (16),
    .AVG_LOG2  (2),
    .MAX_CM    (400),
    .NEAR_CM   (10),
    .FAR_CM    (15),
    .HOLD      (3),
    .TIMEOUT_MS(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_cm   (sample_cm),
    .avg_cm      (avg_cm),
    .avg_valid   (avg_valid),
    .near        (near),
    .near_rise   (near_rise),
    .near_fall   (near_fall),
    .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_avg(input logic [15:0] a, input logic n, input logic r, input logic f);
    exp_t e;
    e.avg = a; e.nr = n; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  // Called on a negedge; strobes one sample and returns two negedges later.
  task automatic send(input logic [15:0] cm);
    sample_valid = 1'b1;
    sample_cm    = cm;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_cm    = 16'd0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_avg_cm"},    32'(avg_cm),  32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_near"},      32'(near),      32'd0);
    check({tag, "_near_rise"}, 32'(near_rise), 32'd0);
    check({tag, "_near_fall"}, 32'(near_fall), 32'd0);
    check({tag, "_fault"},     32'(sensor_fault), 32'd0);
  endtask

  // Monitor: pops an expectation on each avg_valid, checks flags one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("near", 32'(near), 32'(cur.nr));
          check("near_rise", 32'(near_rise), 32'(cur.rise));
          check("near_fall", 32'(near_fall), 32'(cur.fall));
          pend = 1'b0;
        end else if (strict && (near_rise || near_fall)) begin
          check("stray_pulse", 32'({near_rise, near_fall}), 32'd0);
        end
        if (avg_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_avg_valid", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            check("avg_cm", 32'(avg_cm), 32'(cur.avg));
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_cm    = 16'd0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Fill: only the fourth sample produces an average.
    for (int i = 0; i < 3; i++) send(16'd20);
    expect_avg(16'd20, 1'b0, 1'b0, 1'b0); send(16'd20);

    // Entry: 16 and 12 do not qualify; 8, 4, 4 are three qualifying averages.
    expect_avg(16'd16, 1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd12, 1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd8,  1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd4,  1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd4,  1'b1, 1'b1, 1'b0); send(16'd4);

    // Hysteresis band, an interrupted far run, then a full far run.
    expect_avg(16'd12, 1'b1, 1'b0, 1'b0); send(16'd36);
    expect_avg(16'd13, 1'b1, 1'b0, 1'b0); send(16'd8);
    expect_avg(16'd14, 1'b1, 1'b0, 1'b0); send(16'd8);
    expect_avg(16'd18, 1'b1, 1'b0, 1'b0); send(16'd20);
    expect_avg(16'd11, 1'b1, 1'b0, 1'b0); send(16'd8);
    expect_avg(16'd19, 1'b1, 1'b0, 1'b0); send(16'd40);
    expect_avg(16'd22, 1'b1, 1'b0, 1'b0); send(16'd20);
    expect_avg(16'd22, 1'b0, 1'b0, 1'b1); send(16'd20);

    // A zero sample must not enter the buffer.
    send(16'd0);
    expect_avg(16'd22, 1'b0, 1'b0, 1'b0); send(16'd8);

    // Rejected samples do not restart the silence timer.
    send(16'd0);
    sample_valid = 1'b1;
    sample_cm    = 16'd500;
    @(negedge clk);
    check("fault_before_limit", 32'(sensor_fault), 32'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    sample_cm    = 16'd0;
    check("fault_at_limit", 32'(sensor_fault), 32'd1);
    check("flushed_avg", 32'(avg_cm), 32'd0);

    // Fault clears on the next accepted sample; refill and go near again.
    send(16'd4);
    check("fault_cleared", 32'(sensor_fault), 32'd0);
    send(16'd4);
    send(16'd4);
    expect_avg(16'd4, 1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd4, 1'b0, 1'b0, 1'b0); send(16'd4);
    expect_avg(16'd4, 1'b1, 1'b1, 1'b0); send(16'd4);

    // Timeout while near: forced fall pulse.
    strict = 1'b0;
    repeat (3) @(negedge clk);
    check("near_fault_before", 32'(sensor_fault), 32'd0);
    check("near_before_timeout", 32'(near), 32'd1);
    @(negedge clk);
    check("near_fault_at", 32'(sensor_fault), 32'd1);
    check("near_after_timeout", 32'(near), 32'd0);
    check("timeout_fall_pulse", 32'(near_fall), 32'd1);
    check("timeout_avg_flushed", 32'(avg_cm), 32'd0);
    @(negedge clk);
    check("timeout_fall_single", 32'(near_fall), 32'd0);
    strict = 1'b1;

    // Collision: a sample on the limit cycle prevents the fault.
    send(16'd4);
    check("collision_clear", 32'(sensor_fault), 32'd0);
    repeat (3) @(negedge clk);
    send(16'd4);
    check("collision_no_fault", 32'(sensor_fault), 32'd0);
    send(16'd4);
    expect_avg(16'd4, 1'b0, 1'b0, 1'b0); send(16'd4);
    @(negedge clk);

    // Reset while pending near.
    check("pre_reset_avg", 32'(avg_cm), 32'd4);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("postreset");
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
